// File: rtl/hwpe_tcdm_source_fetch.sv
// rtl/hwpe_tcdm_source_fetch.sv - NPX-port TCDM read fetcher feeding an in-order beat stream
// Requests are held per port until granted, responses are staged until the whole beat is back.
module hwpe_tcdm_source_fetch #(
  parameter int NPX        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        addr_valid_i,
  input  logic [NPX*32-1:0]           addr_i,
  output logic                        addr_inc_o,
  output logic [NPX-1:0]              tcdm_req_o,
  output logic [NPX*32-1:0]           tcdm_add_o,
  output logic [NPX-1:0]              tcdm_wen_o,
  output logic [NPX*DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic [NPX-1:0]              tcdm_gnt_i,
  input  logic [NPX-1:0]              tcdm_r_valid_i,
  input  logic [NPX*DATA_WIDTH-1:0]   tcdm_r_rdata_i,
  output logic                        stream_valid_o,
  output logic [NPX*DATA_WIDTH-1:0]   stream_data_o,
  input  logic                        stream_ready_i,
  output logic                        busy_o
);

  localparam int BW = NPX * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic            r_run;
  logic            r_clear_q;
  logic [NPX-1:0]  r_granted;
  logic [1:0]      r_pending;
  logic [NPX-1:0]  r_stage_valid;
  logic [BW-1:0]   r_stage_data;
  logic [BW-1:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [CW:0]     w_credit;
  logic            w_issue;
  logic [NPX-1:0]  w_req;
  logic [NPX-1:0]  w_new_gnt;
  logic            w_all_granted;
  logic            w_inc;
  logic [NPX-1:0]  w_rvalid;
  logic [NPX-1:0]  w_stage_all;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic [BW-1:0]   w_beat;

  // Credits cover beats already granted but not yet written, so the FIFO can never overflow.
  assign w_credit      = {1'b0, r_count} + (CW+1)'(r_pending);
  assign w_issue       = r_run & addr_valid_i & ~clear_i & (w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_req         = {NPX{w_issue}} & ~r_granted;
  assign w_new_gnt     = w_req & tcdm_gnt_i;
  assign w_all_granted = &(r_granted | w_new_gnt);
  assign w_inc         = w_issue & w_all_granted;

  // Responses to beats issued before a flush land in the flush cycle or the one after.
  assign w_rvalid      = tcdm_r_valid_i & {NPX{~(clear_i | r_clear_q)}};
  assign w_stage_all   = r_stage_valid | w_rvalid;
  assign w_push        = (&w_stage_all) & ~clear_i;
  assign w_pop         = (r_count != '0) & stream_ready_i;
  assign w_full        = (r_count == CW'(FIFO_DEPTH));

  always_comb begin
    w_beat = r_stage_data;
    for (int i = 0; i < NPX; i++) begin
      if (w_rvalid[i]) w_beat[i*DATA_WIDTH +: DATA_WIDTH] = tcdm_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_clear_q     <= 1'b0;
      r_granted     <= '0;
      r_pending     <= '0;
      r_stage_valid <= '0;
      r_stage_data  <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_run     <= 1'b1;
      r_clear_q <= clear_i;
      if (clear_i) begin
        r_granted     <= '0;
        r_pending     <= '0;
        r_stage_valid <= '0;
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_count       <= '0;
      end else begin
        if (w_inc) r_granted <= '0;
        else       r_granted <= r_granted | w_new_gnt;

        r_stage_data <= w_beat;
        if (w_push) r_stage_valid <= '0;
        else        r_stage_valid <= w_stage_all;

        if (w_inc && !w_push && r_pending != 2'd2) r_pending <= r_pending + 2'd1;
        else if (!w_inc && w_push && r_pending != 2'd0) r_pending <= r_pending - 2'd1;

        if (w_push) begin
          r_fifo[r_wptr] <= w_beat;
          r_wptr         <= r_wptr + AW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);

        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign addr_inc_o     = w_inc;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = addr_i;
  assign tcdm_wen_o     = '1;
  assign tcdm_be_o      = '1;
  assign stream_valid_o = (r_count != '0);
  assign stream_data_o  = r_fifo[r_rptr];
  assign busy_o         = (r_pending != 2'd0) | (|r_granted) | (r_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_hwpe_tcdm_source_fetch.sv
// tb/tb_hwpe_tcdm_source_fetch.sv - directed scoreboard bench for hwpe_tcdm_source_fetch
// The TCDM model returns each port's address as its read data one cycle after grant.
module tb_hwpe_tcdm_source_fetch;
  localparam int NPX = 4;
  localparam int DW  = 32;
  localparam int BW  = NPX * DW;

  logic              clk;
  logic              rst_n;
  logic              clear_i;
  logic              addr_valid_i;
  logic [NPX*32-1:0] addr_i;
  logic              addr_inc_o;
  logic [NPX-1:0]    tcdm_req_o;
  logic [NPX*32-1:0] tcdm_add_o;
  logic [NPX-1:0]    tcdm_wen_o;
  logic [NPX*DW/8-1:0] tcdm_be_o;
  logic [NPX-1:0]    tcdm_gnt_i;
  logic [NPX-1:0]    tcdm_r_valid_i;
  logic [BW-1:0]     tcdm_r_rdata_i;
  logic              stream_valid_o;
  logic [BW-1:0]     stream_data_o;
  logic              stream_ready_i;
  logic              busy_o;

  hwpe_tcdm_source_fetch #(.NPX(NPX), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .addr_inc_o(addr_inc_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i), .stream_valid_o(stream_valid_o),
    .stream_data_o(stream_data_o), .stream_ready_i(stream_ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [BW-1:0] exp_q[$];
  int            beats_left;
  logic [31:0]   gen_base;
  logic [NPX-1:0] inj_rvalid;

  int            cyc, first_req, first_out, n_inc, n_out, streak, max_streak;
  logic          s_inc, s_valid, s_busy, s_ready;
  logic [NPX-1:0] s_req, s_grant;
  logic [BW-1:0] s_add, s_data;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] a0, a1, a2, a3);
    addr_i       = {a3, a2, a1, a0};
    addr_valid_i = 1'b1;
    exp_q.push_back({a3, a2, a1, a0});
  endtask

  task automatic start_stream(input logic [31:0] base, input int n);
    gen_base   = base;
    beats_left = n;
    present(base, base + 32'd4, base + 32'd8, base + 32'd12);
  endtask

  task automatic one_beat(input logic [31:0] a0, a1, a2, a3);
    beats_left = 1;
    present(a0, a1, a2, a3);
  endtask

  task automatic reset_counters();
    cyc = 0; first_req = -1; first_out = -1;
    n_inc = 0; n_out = 0; streak = 0; max_streak = 0;
  endtask

  // One clock: sample at negedge, score output, then drive responses and the next beat.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_inc   = addr_inc_o;
    s_req   = tcdm_req_o;
    s_grant = tcdm_req_o & tcdm_gnt_i;
    s_add   = tcdm_add_o;
    s_valid = stream_valid_o;
    s_data  = stream_data_o;
    s_busy  = busy_o;
    s_ready = stream_ready_i;
    if (s_req != '0 && first_req < 0) first_req = cyc;
    if (s_inc) begin
      n_inc++; streak++;
      if (streak > max_streak) max_streak = streak;
    end else begin
      streak = 0;
    end
    if (s_valid && s_ready) begin
      if (first_out < 0) first_out = cyc;
      n_out++;
      check("sb_has_entry", BW'(exp_q.size() != 0), BW'(1));
      if (exp_q.size() != 0) check("sb_data", s_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    tcdm_r_valid_i = s_grant | inj_rvalid;
    inj_rvalid     = '0;
    for (int i = 0; i < NPX; i++) tcdm_r_rdata_i[i*DW +: DW] = s_add[i*32 +: 32];
    if (s_inc && beats_left > 0) begin
      beats_left--;
      gen_base = gen_base + 32'd16;
      if (beats_left > 0) present(gen_base, gen_base + 32'd4, gen_base + 32'd8, gen_base + 32'd12);
      else addr_valid_i = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((exp_q.size() != 0 || s_busy || s_valid) && k < max_cyc);
    check({tag, "_sb_empty"}, BW'(exp_q.size()), BW'(0));
    check({tag, "_idle"}, BW'(s_busy), BW'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   BW'(tcdm_req_o),     BW'(0));
    check({tag, "_inc"},   BW'(addr_inc_o),     BW'(0));
    check({tag, "_valid"}, BW'(stream_valid_o), BW'(0));
    check({tag, "_busy"},  BW'(busy_o),         BW'(0));
    check({tag, "_data"},  stream_data_o,       BW'(0));
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; addr_valid_i = 1'b0; addr_i = '0;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_rdata_i = '0; stream_ready_i = 1'b0;
    inj_rvalid = '0; beats_left = 0; gen_base = '0;
    reset_counters();

    // Reset state, with a live address offered to show requests are held off.
    #2;
    addr_valid_i = 1'b1;
    tcdm_gnt_i   = '1;
    #1;
    check_reset_outputs("rst");
    check("rst_wen", BW'(tcdm_wen_o), BW'(4'hF));
    check("rst_be",  BW'(tcdm_be_o),  BW'(16'hFFFF));
    addr_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate streaming of 8 beats.
    reset_counters();
    stream_ready_i = 1'b1;
    tcdm_gnt_i     = '1;
    start_stream(32'h100, 8);
    drain("A", 40);
    check("A_inc_count",  BW'(n_inc), BW'(8));
    check("A_inc_streak", BW'(max_streak), BW'(8));
    check("A_out_count",  BW'(n_out), BW'(8));
    check("A_latency",    BW'(first_out - first_req), BW'(2));

    // Port 2 granted 3 cycles late, with addr_valid dropping mid-beat.
    reset_counters();
    tcdm_gnt_i = 4'b1011;
    one_beat(32'h200, 32'h204, 32'h208, 32'h20C);
    step();
    check("B_req_c0", BW'(s_req), BW'(4'b1111));
    addr_valid_i = 1'b0;
    step();
    check("B_req_drop", BW'(s_req), BW'(0));
    check("B_busy_hold", BW'(s_busy), BW'(1));
    addr_valid_i = 1'b1;
    step();
    check("B_req_c2", BW'(s_req), BW'(4'b0100));
    check("B_inc_c2", BW'(s_inc), BW'(0));
    tcdm_gnt_i = 4'b1111;
    step();
    check("B_inc_c3", BW'(s_inc), BW'(1));
    drain("B", 20);
    check("B_inc_count", BW'(n_inc), BW'(1));
    check("B_out_count", BW'(n_out), BW'(1));

    // Out-of-order grants 3,1,0,2 assemble into one beat.
    reset_counters();
    tcdm_gnt_i = 4'b1000;
    one_beat(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    step();
    tcdm_gnt_i = 4'b0010;
    step();
    tcdm_gnt_i = 4'b0001;
    step();
    check("C_inc_early", BW'(n_inc), BW'(0));
    tcdm_gnt_i = 4'b0100;
    step();
    check("C_inc_last", BW'(s_inc), BW'(1));
    tcdm_gnt_i = 4'b1111;
    drain("C", 20);
    check("C_out_count", BW'(n_out), BW'(1));

    // Back-pressure: credits stop issue once the FIFO is accounted full.
    reset_counters();
    stream_ready_i = 1'b0;
    tcdm_gnt_i     = 4'b1111;
    start_stream(32'h300, 8);
    repeat (12) step();
    check("D_inc_stall", BW'(n_inc), BW'(4));
    check("D_req_stall", BW'(s_req), BW'(0));
    check("D_valid",     BW'(s_valid), BW'(1));
    check("D_busy",      BW'(s_busy), BW'(1));
    stream_ready_i = 1'b1;
    drain("D", 60);
    check("D_inc_count", BW'(n_inc), BW'(8));
    check("D_out_count", BW'(n_out), BW'(8));

    // Flush with two beats queued and one outstanding; late responses ignored.
    reset_counters();
    stream_ready_i = 1'b0;
    tcdm_gnt_i     = 4'b1111;
    start_stream(32'h400, 3);
    repeat (3) step();
    check("E_inc_count", BW'(n_inc), BW'(3));
    clear_i    = 1'b1;
    inj_rvalid = 4'b1111;
    step();
    check("E_pre_busy",  BW'(s_busy), BW'(1));
    check("E_pre_valid", BW'(s_valid), BW'(1));
    clear_i = 1'b0;
    exp_q.delete();
    step();
    check("E_valid", BW'(s_valid), BW'(0));
    check("E_busy",  BW'(s_busy), BW'(0));
    stream_ready_i = 1'b1;
    repeat (5) step();
    check("E_valid_later", BW'(s_valid), BW'(0));
    check("E_busy_later",  BW'(s_busy), BW'(0));
    check("E_no_output",   BW'(n_out), BW'(0));

    // Asynchronous reset mid-stream, then a clean restart.
    reset_counters();
    stream_ready_i = 1'b1;
    tcdm_gnt_i     = 4'b1111;
    start_stream(32'h500, 8);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("F_rst");
    exp_q.delete();
    beats_left     = 0;
    addr_valid_i   = 1'b0;
    tcdm_r_valid_i = '0;
    repeat (2) step();
    rst_n = 1'b1;
    reset_counters();
    start_stream(32'h600, 8);
    drain("F", 40);
    check("F_inc_count",  BW'(n_inc), BW'(8));
    check("F_inc_streak", BW'(max_streak), BW'(8));
    check("F_out_count",  BW'(n_out), BW'(8));
    check("F_latency",    BW'(first_out - first_req), BW'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
